// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (Moore): sequences the shared datapath, one state per cycle.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, illegal 2 cycles; each mem_ready=0 cycle adds one.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; reset forces all strobes low.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_q, state_d, dec_state;
  logic   is_lw_q;
  logic   pc_write, pc_write_cond;
  logic   mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Only DECODE sees a valid opcode; remember lw vs sw for MEMADR.
      if (state_q == S_DECODE) is_lw_q <= (opcode == OP_LW);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // During reset the mux selects already present the FETCH setup.
  assign dec_state = reset ? S_FETCH : state_q;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_raw   = 1'b0;
    case (dec_state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_raw = 1'b0;
          default:                                       illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        i_or_d       = 1'b1;
        mem_read_raw = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        i_or_d        = 1'b1;
        mem_write_raw = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en      = ~reset & (pc_write | (pc_write_cond & zero));
  assign mem_read   = ~reset & mem_read_raw;
  assign mem_write  = ~reset & mem_write_raw;
  assign ir_write   = ~reset & ir_write_raw;
  assign reg_write  = ~reset & reg_write_raw;
  assign illegal_op = ~reset & illegal_raw;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle vector table checked through a scoreboard queue,
// followed by per-instruction cycle counts.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  outs_t act;
  assign act = {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  vec_t  vecs[$];
  outs_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Expected controls for a given current state, taken from the state output table.
  function automatic outs_t exp_of(input logic [3:0] st, input logic [5:0] op,
                                   input logic z, input logic mr, input logic rst);
    outs_t o;
    logic [3:0] d;
    o = '0;
    o.st = st;
    d = rst ? 4'd0 : st;
    case (d)
      4'd0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      4'd1:  begin
        o.alu_src_b = 2'b11;
        o.illegal_op = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
      end
      4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd3:  begin o.i_or_d = 1; o.mem_read = 1; end
      4'd4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      4'd5:  begin o.i_or_d = 1; o.mem_write = mr; end
      4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      4'd7:  begin o.reg_dst = 1; o.reg_write = 1; end
      4'd8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = z; end
      4'd9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd10: o.reg_write = 1;
      4'd11: begin o.pc_source = 2'b10; o.pc_en = 1; end
      default: ;
    endcase
    if (rst) begin
      o.pc_en = 0; o.mem_read = 0; o.mem_write = 0;
      o.ir_write = 0; o.reg_write = 0; o.illegal_op = 0;
    end
    return o;
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic z,
                     input logic mr, input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    outs_t       exp;
    outs_t       got;
    int          n;
    logic [5:0]  cc_op[7];
    int          cc_len[7];

    // reset held, then lw with no stalls
    add(1, 6'h00, 0, 1, 0); add(1, 6'h00, 0, 1, 0); add(1, 6'h00, 0, 1, 0);
    add(0, 6'h23, 0, 1, 0); add(0, 6'h23, 0, 1, 1); add(0, 6'h23, 0, 0, 2);
    add(0, 6'h23, 0, 1, 3); add(0, 6'h23, 0, 0, 4);
    // sw with 3 stall cycles in MEMWR; opcode change after DECODE ignored
    add(0, 6'h2B, 0, 1, 0); add(0, 6'h2B, 0, 1, 1); add(0, 6'h23, 0, 1, 2);
    add(0, 6'h23, 0, 0, 5); add(0, 6'h2B, 0, 0, 5); add(0, 6'h2B, 0, 0, 5);
    add(0, 6'h2B, 0, 1, 5);
    // FETCH stall, beq taken, beq not taken
    add(0, 6'h04, 1, 0, 0); add(0, 6'h04, 1, 1, 0); add(0, 6'h04, 1, 1, 1);
    add(0, 6'h04, 1, 1, 8); add(0, 6'h04, 0, 1, 0); add(0, 6'h04, 0, 1, 1);
    add(0, 6'h04, 0, 1, 8);
    // R-type, addi, j
    add(0, 6'h00, 0, 1, 0); add(0, 6'h00, 0, 1, 1); add(0, 6'h08, 1, 1, 6);
    add(0, 6'h00, 0, 1, 7); add(0, 6'h08, 0, 1, 0); add(0, 6'h08, 0, 1, 1);
    add(0, 6'h08, 0, 1, 9); add(0, 6'h08, 0, 1, 10); add(0, 6'h02, 0, 1, 0);
    add(0, 6'h02, 0, 1, 1); add(0, 6'h02, 0, 1, 11);
    // illegal opcode
    add(0, 6'h3F, 0, 1, 0); add(0, 6'h3F, 0, 1, 1);
    // reset during stalled MEMRD
    add(0, 6'h23, 0, 1, 0); add(0, 6'h23, 0, 1, 1); add(0, 6'h23, 0, 1, 2);
    add(0, 6'h23, 0, 0, 3); add(1, 6'h23, 0, 1, 3);
    // reset during stalled MEMWR, with mem_ready arriving in the reset cycle
    add(0, 6'h2B, 0, 1, 0); add(0, 6'h2B, 0, 1, 1); add(0, 6'h2B, 0, 1, 2);
    add(0, 6'h2B, 0, 0, 5); add(1, 6'h2B, 0, 1, 5); add(0, 6'h00, 0, 1, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset     = vecs[i].rst;
      opcode    = vecs[i].op;
      zero      = vecs[i].z;
      mem_ready = vecs[i].mr;
      sb_q.push_back(exp_of(vecs[i].st, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].rst));
      @(negedge clk);
      exp = sb_q.pop_front();
      got = act;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL row%0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, got.st, got, exp.st, exp);
      end
    end

    // Whole-instruction lengths with mem_ready high, FETCH to next FETCH.
    cc_op[0] = 6'h23; cc_len[0] = 5;
    cc_op[1] = 6'h2B; cc_len[1] = 4;
    cc_op[2] = 6'h00; cc_len[2] = 4;
    cc_op[3] = 6'h08; cc_len[3] = 4;
    cc_op[4] = 6'h04; cc_len[4] = 3;
    cc_op[5] = 6'h02; cc_len[5] = 3;
    cc_op[6] = 6'h3F; cc_len[6] = 2;
    mem_ready = 1'b1;
    zero = 1'b0;
    for (int k = 0; k < 7; k++) begin
      opcode = cc_op[k];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (state != 4'd0 && n < 20);
      n_cmp++;
      if (n != cc_len[k]) begin
        n_bad++;
        $display("FAIL cycles op=%h: got %0d cycles, want %0d", cc_op[k], n, cc_len[k]);
      end
    end

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore FSM that sequences the shared MIPS datapath over multiple cycles, replacing per-instruction hardwired control. It drives every 2:1 and 4:1 mux select, the register, memory and IR write strobes, and the PC enable. It stalls on a memory ready handshake. It sits between the instruction register opcode field, the ALU zero flag and the datapath muxes.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_J, 6'h02, jump opcode
OP_ADDI, 6'h08, add-immediate opcode

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from the IR; sampled in DECODE only
zero  in  1  ALU zero flag; used in BRANCH only
mem_ready  in  1  memory done; completes FETCH/MEMRD/MEMWR
pc_en  out  1  PC load = pc_write | (pc_write_cond & zero)
i_or_d  out  1  address mux select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  write-register mux: 0 = rt, 1 = rd
mem_to_reg  out  1  write-data mux: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  4:1 select: 00 = reg B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on an undecodable opcode
state  out  4  current state, for debug and verification

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 are unreachable and go to FETCH.
- Reset: with reset high at an edge, state <= FETCH. While reset is high, pc_en, mem_read, mem_write, ir_write, reg_write and illegal_op are forced to 0 combinationally. All other outputs show the FETCH decode.
- Outputs are pure functions of state. The exceptions are pc_en (also uses zero) and the stall gating below. Every signal not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready. If mem_ready=0, stay in FETCH. If mem_ready=1, go to DECODE.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDIEX
  - anything else -> FETCH, with illegal_op=1 in this DECODE cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if the opcode latched at DECODE was LW, else MEMWR. The controller holds a 1-bit lw/sw flag captured in DECODE.
- MEMRD: i_or_d=1, mem_read=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: i_or_d=1, mem_write=mem_ready. Hold until mem_ready, then FETCH. At most one write strobe per store.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1 (so pc_en=zero), then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JUMP: pc_source=10, pc_write=1, then FETCH.
- Cycle counts with mem_ready tied high:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
  - Each stall cycle adds 1.
- Opcode changes outside DECODE are ignored. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- reset in any state, including a stalled MEMWR, returns to FETCH on that edge. No write strobe is asserted in the reset cycle.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> state=0, all strobes 0 during reset; first post-reset cycle shows mem_read=1, ir_write=1, pc_en=1, alu_src_b=01.
- opcode=6'h23, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; total 5 cycles.
- opcode=6'h2B, mem_ready low 3 cycles in MEMWR -> state stays 5 for 3 cycles with mem_write=0, then mem_write=1 for exactly 1 cycle, then FETCH.
- opcode=6'h04 with zero=1, then a repeat with zero=0 -> pc_en=1 and pc_source=01 in BRANCH for the first; pc_en=0 for the second; 3 cycles each.
- opcode=6'h00, then 6'h08, then 6'h02 -> R-type ALUWB has reg_dst=1, alu_op=10; addi ADDIWB has reg_dst=0, alu_src_b=10 in ADDIEX; j JUMP has pc_source=10, pc_en=1; cycle counts 4/4/3.
- opcode=6'h3F -> illegal_op=1 for exactly 1 cycle in DECODE, no reg_write/mem_write, back in FETCH next cycle. Separately, reset asserted mid-MEMRD -> FETCH next cycle, no reg_write.
